// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 64-word data memory between the CPU
// load/store path and a DMA burst engine. The CPU wins each beat, but a
// starvation guard forces one DMA beat after CPU_MAX_RUN back-to-back CPU
// grants during a burst. Read data is returned registered, one cycle after
// the grant.
// Optional feature: define DMEM_ARB_PERF_EN to enable the saturating CPU
// stall counter on perf_cpu_stalls; otherwise that port is tied to zero.
module dmem_arbiter #(
    parameter int LEN_W       = 6,
    parameter int CPU_MAX_RUN = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [31:0]      c_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [LEN_W-1:0] d_len,
    output logic             d_ack,
    input  logic [31:0]      d_wdata,
    output logic             d_wready,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_done,
    output logic             d_busy,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic [CNT_W-1:0] perf_cpu_stalls
);

    // The run counter only has to reach CPU_MAX_RUN; keep it at least 1 bit
    // wide so CPU_MAX_RUN = 0 (DMA always wins) still elaborates.
    localparam int RUN_W = (CPU_MAX_RUN < 1) ? 1 : $clog2(CPU_MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(CPU_MAX_RUN);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      burst_addr;
    logic [31:0]      burst_addr_next;
    logic [LEN_W-1:0] beats_left;
    logic [LEN_W-1:0] beats_left_next;
    logic             burst_we;
    logic             burst_we_next;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_next;
    logic             dma_beat;
    logic             last_beat;

    // Word alignment drops the low address bits of the descriptor.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, d_addr[1:0]};

    // Burst sequencing registers; a reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_addr <= '0;
            beats_left <= '0;
            burst_we   <= 1'b0;
            run_cnt    <= '0;
        end else begin
            state      <= state_next;
            burst_addr <= burst_addr_next;
            beats_left <= beats_left_next;
            burst_we   <= burst_we_next;
            run_cnt    <= run_cnt_next;
        end
    end

    // Arbitration, burst next-state and memory port steering; every grant
    // and strobe is forced low while reset is asserted.
    always_comb begin
        state_next      = state;
        burst_addr_next = burst_addr;
        beats_left_next = beats_left;
        burst_we_next   = burst_we;
        run_cnt_next    = run_cnt;
        c_gnt           = 1'b0;
        d_ack           = 1'b0;
        d_wready        = 1'b0;
        d_busy          = 1'b0;
        dma_beat        = 1'b0;
        last_beat       = 1'b0;
        mem_addr        = '0;
        mem_we          = 1'b0;
        mem_wd          = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    c_gnt = c_req;
                    d_ack = d_req;
                    if (d_req) begin
                        burst_addr_next = {d_addr[31:2], 2'b00};
                        beats_left_next = d_len;
                        burst_we_next   = d_we;
                        run_cnt_next    = '0;
                        state_next      = BURST;
                    end
                end
                BURST: begin
                    d_busy = 1'b1;
                    if (!c_req || (run_cnt == RUN_LIMIT)) begin
                        dma_beat        = 1'b1;
                        d_wready        = burst_we;
                        burst_addr_next = burst_addr + 32'd4;
                        run_cnt_next    = '0;
                        if (beats_left == '0) begin
                            last_beat  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            beats_left_next = beats_left - LEN_W'(1);
                        end
                    end else begin
                        c_gnt        = 1'b1;
                        run_cnt_next = run_cnt + RUN_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
            if (dma_beat) begin
                mem_addr = burst_addr;
                mem_we   = burst_we;
                mem_wd   = d_wdata;
            end else if (c_gnt) begin
                mem_addr = c_addr;
                mem_we   = c_we;
                mem_wd   = c_wdata;
            end
        end
    end

    // Registered read responses and the end-of-burst pulse; rdata holds
    // its value until the requester's next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_done   <= 1'b0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            if (c_gnt && !c_we) begin
                c_rdata <= mem_rd;
            end
            d_rvalid <= dma_beat & ~burst_we;
            if (dma_beat && !burst_we) begin
                d_rdata <= mem_rd;
            end
            d_done <= last_beat;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] stall_cnt;

    // Saturating count of cycles where the CPU asked but was not served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (c_req && !c_gnt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign perf_cpu_stalls = stall_cnt;
`else
    assign perf_cpu_stalls = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed stimulus for dmem_arbiter with a
// transaction-level reference model. The driver predicts grants and memory
// contents and pushes expected read responses into queues; a monitor pops
// and compares whenever the DUT presents a response.
module tb_dmem_arbiter;

    localparam int LEN_W       = 6;
    localparam int CPU_MAX_RUN = 4;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             c_req;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic             c_gnt;
    logic             c_rvalid;
    logic [31:0]      c_rdata;
    logic             d_req;
    logic             d_we;
    logic [31:0]      d_addr;
    logic [LEN_W-1:0] d_len;
    logic             d_ack;
    logic [31:0]      d_wdata;
    logic             d_wready;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic             d_done;
    logic             d_busy;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;
    logic [CNT_W-1:0] perf_cpu_stalls;

    // Clock generation.
    always #5 clk = ~clk;

    dmem_arbiter #(
        .LEN_W(LEN_W),
        .CPU_MAX_RUN(CPU_MAX_RUN),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .c_req(c_req),
        .c_we(c_we),
        .c_addr(c_addr),
        .c_wdata(c_wdata),
        .c_gnt(c_gnt),
        .c_rvalid(c_rvalid),
        .c_rdata(c_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_len(d_len),
        .d_ack(d_ack),
        .d_wdata(d_wdata),
        .d_wready(d_wready),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .d_done(d_done),
        .d_busy(d_busy),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wd(mem_wd),
        .mem_rd(mem_rd),
        .perf_cpu_stalls(perf_cpu_stalls)
    );

    // The shared 64-word memory: combinational read, posedge write.
    logic [31:0] mem_arr [64];
    assign mem_rd = mem_arr[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wd;
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    resp_t cq[$];
    resp_t dq[$];
    int    doneq[$];

    int n_checks = 0;
    int n_fail = 0;
    int cur = 0;
    bit mon_on = 1'b0;
    bit regs_known = 1'b0;
    int dut_stalls = 0;

    // Reference model: memory image plus the burst in progress.
    logic [31:0]      ref_mem [64];
    bit               m_busy = 1'b0;
    logic [31:0]      m_addr = '0;
    int               m_left = 0;
    bit               m_we = 1'b0;
    int               m_streak = 0;
    logic [CNT_W-1:0] m_stalls = '0;
    bit               last_cg = 1'b0;
    bit               last_ack = 1'b0;
    bit               last_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur);
        end
    endtask

    // One clock cycle: predict this cycle's grants from the model, compare,
    // then retire the transaction into the model and move to the next cycle.
    task automatic check_output(input bit zero_chk);
        logic        exp_cg;
        logic        exp_ack;
        logic        exp_beat;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
        int          idx;
        if (last_wr) d_wdata = $urandom;
        @(negedge clk);
        exp_cg = 1'b0; exp_ack = 1'b0; exp_beat = 1'b0;
        exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
        if (rst_n) begin
            if (!m_busy) begin
                exp_cg  = c_req;
                exp_ack = d_req;
            end else if (c_req && m_streak < CPU_MAX_RUN) begin
                exp_cg = 1'b1;
            end else begin
                exp_beat = 1'b1;
            end
            if (exp_beat) begin
                exp_addr = m_addr; exp_we = m_we; exp_wd = d_wdata;
            end else if (exp_cg) begin
                exp_addr = c_addr; exp_we = c_we; exp_wd = c_wdata;
            end
        end
        check("c_gnt", 32'(c_gnt), 32'(exp_cg));
        check("d_ack", 32'(d_ack), 32'(exp_ack));
        check("d_wready", 32'(d_wready), 32'(exp_beat & m_we));
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wd", mem_wd, exp_wd);
        if (rst_n) check("d_busy", 32'(d_busy), 32'(m_busy));
        if (regs_known) begin
`ifdef DMEM_ARB_PERF_EN
            check("perf_cpu_stalls", 32'(perf_cpu_stalls), 32'(m_stalls));
`else
            check("perf_cpu_stalls", 32'(perf_cpu_stalls), 32'd0);
`endif
        end
        if (zero_chk) begin
            check("rst_c_rvalid", 32'(c_rvalid), 32'd0);
            check("rst_c_rdata", c_rdata, 32'd0);
            check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            check("rst_d_rdata", d_rdata, 32'd0);
            check("rst_d_done", 32'(d_done), 32'd0);
            check("rst_perf", 32'(perf_cpu_stalls), 32'd0);
        end
        if (rst_n && c_req && !c_gnt) dut_stalls++;
        last_wr = exp_beat & m_we;
        if (!rst_n) begin
            m_busy = 1'b0; m_streak = 0; m_stalls = '0;
        end else begin
            if (c_req && !exp_cg && (m_stalls != '1)) m_stalls++;
            if (exp_cg) begin
                idx = int'(c_addr[7:2]);
                if (c_we) ref_mem[idx] = c_wdata;
                else cq.push_back('{cyc: cur + 1, data: ref_mem[idx]});
                if (m_busy) m_streak++;
            end
            if (exp_beat) begin
                idx = int'(m_addr[7:2]);
                if (m_we) ref_mem[idx] = d_wdata;
                else dq.push_back('{cyc: cur + 1, data: ref_mem[idx]});
                m_streak = 0;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    doneq.push_back(cur + 1);
                end else begin
                    m_left--;
                    m_addr = m_addr + 32'd4;
                end
            end else if (exp_ack) begin
                m_busy = 1'b1; m_addr = {d_addr[31:2], 2'b00};
                m_left = int'(d_len); m_we = d_we; m_streak = 0;
            end
        end
        last_cg = exp_cg;
        last_ack = exp_ack;
        @(posedge clk);
        #1;
        cur++;
    endtask

    // Present a burst descriptor for one cycle.
    task automatic apply_stimulus(input bit we, input logic [31:0] addr, input int len);
        d_req = 1'b1; d_we = we; d_addr = addr; d_len = LEN_W'(len);
        d_wdata = $urandom;
        check_output(1'b0);
        d_req = 1'b0;
    endtask

    // Run the model's burst to completion, optionally with the CPU asking
    // every cycle; an expired cycle budget counts as a failure.
    task automatic finish_burst(input bit cpu_busy, input int bound);
        int n;
        n = 0;
        while (m_busy && n < bound) begin
            if (cpu_busy) begin
                if (last_cg) begin
                    c_req = 1'b1; c_we = 1'b0; c_addr = 32'($urandom_range(0, 63)) << 2;
                end
            end else begin
                c_req = 1'b0;
            end
            check_output(1'b0);
            n++;
        end
        if (m_busy) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL burst_timeout: burst still open after %0d cycles, required completion", bound);
        end
        c_req = 1'b0;
        check_output(1'b0);
    endtask

    // Response monitor: pops an expectation whenever one is due or the DUT
    // raises a valid, so missing, spurious and wrong responses all show up.
    always @(negedge clk) begin
        bit exp_v;
        if (mon_on) begin
            while (cq.size() > 0 && cq[0].cyc < cur) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL c_rvalid_missed: no response, required data %h", cq[0].data);
                void'(cq.pop_front());
            end
            exp_v = (cq.size() > 0 && cq[0].cyc == cur);
            if (exp_v || c_rvalid) begin
                check("c_rvalid", 32'(c_rvalid), 32'(exp_v));
                if (exp_v) begin
                    if (c_rvalid) check("c_rdata", c_rdata, cq[0].data);
                    void'(cq.pop_front());
                end
            end
            while (dq.size() > 0 && dq[0].cyc < cur) begin
                n_checks++; n_fail++;
                $display("[TB] FAIL d_rvalid_missed: no response, required data %h", dq[0].data);
                void'(dq.pop_front());
            end
            exp_v = (dq.size() > 0 && dq[0].cyc == cur);
            if (exp_v || d_rvalid) begin
                check("d_rvalid", 32'(d_rvalid), 32'(exp_v));
                if (exp_v) begin
                    if (d_rvalid) check("d_rdata", d_rdata, dq[0].data);
                    void'(dq.pop_front());
                end
            end
            while (doneq.size() > 0 && doneq[0] < cur) void'(doneq.pop_front());
            exp_v = (doneq.size() > 0 && doneq[0] == cur);
            if (exp_v || d_done) begin
                check("d_done", 32'(d_done), 32'(exp_v));
                if (exp_v) void'(doneq.pop_front());
            end
        end
    end

    // Directed scenarios followed by a randomized traffic phase.
    initial begin
        int stalls_before;
        rst_n = 1'b0; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        @(posedge clk);
        #1;
        check_output(1'b0);
        regs_known = 1'b1;
        mon_on = 1'b1;
        check_output(1'b1);
        rst_n = 1'b1;

        $display("[TB] filling memory through the CPU port");
        for (int i = 0; i < 64; i++) begin
            c_req = 1'b1; c_we = 1'b1; c_addr = 32'(i) << 2; c_wdata = $urandom;
            check_output(1'b0);
        end

        $display("[TB] CPU write then read at 0x10");
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
        check_output(1'b0);
        c_we = 1'b0;
        check_output(1'b0);
        c_req = 1'b0;
        check_output(1'b0);

        $display("[TB] DMA write burst of 4 at 0x20");
        apply_stimulus(1'b1, 32'h20, 3);
        finish_burst(1'b0, 20);

        $display("[TB] DMA read burst of 2 at 0x20");
        apply_stimulus(1'b0, 32'h20, 1);
        finish_burst(1'b0, 20);

        $display("[TB] 8-beat DMA read with CPU requesting every cycle");
        stalls_before = dut_stalls;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        apply_stimulus(1'b0, 32'h0, 7);
        finish_burst(1'b1, 100);
        check("stalls_per_burst", 32'(dut_stalls - stalls_before), 32'd8);

        $display("[TB] reset after beat 2 of a 5-beat burst");
        apply_stimulus(1'b1, 32'h40, 4);
        check_output(1'b0);
        check_output(1'b0);
        rst_n = 1'b0;
        check_output(1'b0);
        rst_n = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_len = LEN_W'(2);
        check_output(1'b1);
        d_req = 1'b0;
        finish_burst(1'b0, 20);

        $display("[TB] burst wrapping the address space");
        apply_stimulus(1'b1, 32'hFFFF_FFFC, 1);
        finish_burst(1'b0, 20);
        apply_stimulus(1'b0, 32'hFFFF_FFFE, 1);
        finish_burst(1'b0, 20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            if (!c_req || last_cg) begin
                c_req = ($urandom_range(0, 99) < 55);
                c_we = 1'($urandom_range(0, 1));
                c_addr = $urandom;
                c_wdata = $urandom;
            end
            if (!d_req || last_ack) begin
                d_req = ($urandom_range(0, 99) < 10);
                d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(0, 5));
            end
            rst_n = ($urandom_range(0, 299) != 0);
            check_output(1'b0);
        end
        rst_n = 1'b1;
        d_req = 1'b0;
        finish_burst(1'b0, 200);
        check_output(1'b0);
        check_output(1'b0);
        check("c_resp_queue_drained", 32'(cq.size()), 32'd0);
        check("d_resp_queue_drained", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
